// File: rtl/interp_pkg.sv
// Shared types and constants for the 8-tap interpolator window feeder.
// Provides the sample/window typedefs and the feeder FSM state encoding.
package interp_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned NUM_TAPS   = 8;
  // Index of p[x] inside the window; also the number of samples that must be
  // shifted in after p0 before the first window of a row is complete.
  localparam int unsigned CENTER_TAP = 4;

  typedef logic [SAMPLE_W-1:0]               sample_t;
  typedef logic [NUM_TAPS-1:0][SAMPLE_W-1:0] window_t;

  typedef enum logic [1:0] {
    PRIME,
    STREAM,
    FLUSH
  } feeder_state_t;

endpackage

// File: rtl/interp_tap_window.sv
// 8-entry tap shift register holding the current interpolator window.
// tap[0] is the newest sample, tap[7] the oldest.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset (taps cleared)
//   fill_i         : tap[0] <= data_i, tap[7:1] <= pad_i (start of row)
//   shift_i        : tap[j] <= tap[j-1], tap[0] <= data_i
//   data_i, pad_i  : incoming sample and padding value
//   taps_o         : registered window
// With neither fill_i nor shift_i the taps hold; fill_i has priority.
module interp_tap_window
  import interp_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    fill_i,
  input  logic    shift_i,
  input  sample_t data_i,
  input  sample_t pad_i,
  output window_t taps_o
);

  window_t taps_d, taps_q;

  always_comb begin
    taps_d = taps_q;
    if (fill_i) begin
      for (int j = 1; j < NUM_TAPS; j++) begin
        taps_d[j] = pad_i;
      end
      taps_d[0] = data_i;
    end else if (shift_i) begin
      taps_d = {taps_q[NUM_TAPS-2:0], data_i};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/interp_window_feeder.sv
// Producer side of the 8-tap interpolator window interface.
// Accepts a row-ordered luma stream and emits one registered 8-sample window
// per pixel position with row-edge padding: data_buffer[7-k] = p[x-3+k].
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : sample input handshake
//   data_buffer             : window, [4] = p[x], [0] = p[x+4]
//   out_pos, out_last       : centre column x, x == ROW_LEN-1 flag
//   out_valid/out_ready     : window output handshake
// Build option: define INTERP_ZERO_PAD_EN to pad out-of-row taps with 0
// instead of replicating the edge sample.
module interp_window_feeder #(
  parameter int unsigned ROW_LEN  = 64,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [SAMPLE_W-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [7:0][SAMPLE_W-1:0]     data_buffer,
  output logic [$clog2(ROW_LEN)-1:0]   out_pos,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);
  import interp_pkg::*;

  localparam int unsigned     PosW      = $clog2(ROW_LEN);
  localparam logic [PosW-1:0] LastIdx   = PosW'(ROW_LEN - 1);
  localparam logic [PosW-1:0] CenterIdx = PosW'(CENTER_TAP);

  feeder_state_t             state_d, state_q;
  logic [PosW-1:0]           in_cnt_d, in_cnt_q;
  logic [PosW-1:0]           out_pos_d, out_pos_q;
  logic [1:0]                flush_cnt_d, flush_cnt_q;
  logic                      out_valid_d, out_valid_q;
  logic                      out_last_d, out_last_q;

  logic                      adv;
  logic                      accept;
  logic                      tap_fill;
  logic                      tap_shift;
  logic [SAMPLE_W-1:0]       tap_data;
  logic [SAMPLE_W-1:0]       tap_pad;
  logic [SAMPLE_W-1:0]       flush_val;
  logic [7:0][SAMPLE_W-1:0]  taps;

  // The tap register doubles as the output register, so it may only move
  // when the current window is absent or being taken.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = reset_n & adv & (state_q != FLUSH);
  assign accept   = in_valid & in_ready;

`ifdef INTERP_ZERO_PAD_EN
  assign tap_pad   = '0;
  assign flush_val = '0;
`else
  assign tap_pad   = in_data;
  assign flush_val = taps[0];
`endif

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_pos_d   = out_pos_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    tap_fill    = 1'b0;
    tap_shift   = 1'b0;
    tap_data    = in_data;

    // A taken window retires unless something below emits a new one.
    if (adv) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      PRIME: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == '0) begin
            tap_fill = 1'b1;
          end else begin
            tap_shift = 1'b1;
          end
          if (in_cnt_q == CenterIdx) begin
            out_valid_d = 1'b1;
            out_pos_d   = '0;
            out_last_d  = 1'b0;
            // Shortest rows end on the first window.
            if (in_cnt_q == LastIdx) begin
              state_d     = FLUSH;
              in_cnt_d    = '0;
              flush_cnt_d = '0;
            end else begin
              state_d = STREAM;
            end
          end
        end
      end
      STREAM: begin
        if (accept) begin
          tap_shift   = 1'b1;
          out_valid_d = 1'b1;
          out_pos_d   = out_pos_q + 1'b1;
          out_last_d  = 1'b0;
          if (in_cnt_q == LastIdx) begin
            state_d     = FLUSH;
            in_cnt_d    = '0;
            flush_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          tap_shift   = 1'b1;
          tap_data    = flush_val;
          out_valid_d = 1'b1;
          out_pos_d   = out_pos_q + 1'b1;
          if (flush_cnt_q == 2'd3) begin
            out_last_d  = 1'b1;
            flush_cnt_d = '0;
            in_cnt_d    = '0;
            state_d     = PRIME;
          end else begin
            out_last_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PRIME;
      in_cnt_q    <= '0;
      out_pos_q   <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_pos_q   <= out_pos_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  interp_tap_window u_taps (
    .clock   (clock),
    .reset_n (reset_n),
    .fill_i  (tap_fill),
    .shift_i (tap_shift),
    .data_i  (tap_data),
    .pad_i   (tap_pad),
    .taps_o  (taps)
  );

  assign data_buffer = taps;
  assign out_pos     = out_pos_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_interp_window_feeder.sv
// Bench for interp_window_feeder: a ROW_LEN=8 instance checked every cycle
// against a window-level scoreboard, plus a ROW_LEN=5 instance driven with a
// single directed row. Honours INTERP_ZERO_PAD_EN when defined.
module tb_interp_window_feeder;

  localparam int N      = 8;
  localparam int Budget = 2000;

`ifdef INTERP_ZERO_PAD_EN
  localparam bit ZeroPad = 1'b1;
  localparam logic [63:0] ExpA0 = {8'd0, 8'd0, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
  localparam logic [63:0] ExpA7 = {8'd50, 8'd60, 8'd70, 8'd80, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [63:0] ExpS0 = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  localparam logic [63:0] ExpS4 = {8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [63:0] ExpB0 = {8'd0, 8'd0, 8'd0, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
  localparam logic [63:0] ExpR0 = {8'd0, 8'd0, 8'd0, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105};
`else
  localparam bit ZeroPad = 1'b0;
  localparam logic [63:0] ExpA0 = {8'd10, 8'd10, 8'd10, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
  localparam logic [63:0] ExpA7 = {8'd50, 8'd60, 8'd70, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80};
  localparam logic [63:0] ExpS0 = {8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  localparam logic [63:0] ExpS4 = {8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
  localparam logic [63:0] ExpB0 = {8'd9, 8'd9, 8'd9, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
  localparam logic [63:0] ExpR0 = {8'd101, 8'd101, 8'd101, 8'd101, 8'd102, 8'd103, 8'd104,
                                   8'd105};
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ROW_LEN=8 instance
  logic [7:0]      in_data   = '0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b1;
  logic            in_ready, out_valid, out_last;
  logic [7:0][7:0] data_buffer;
  logic [2:0]      out_pos;

  // ROW_LEN=5 instance
  logic [7:0]      in_data2   = '0;
  logic            in_valid2  = 1'b0;
  logic            out_ready2 = 1'b1;
  logic            in_ready2, out_valid2, out_last2;
  logic [7:0][7:0] data_buffer2;
  logic [2:0]      out_pos2;

  interp_window_feeder #(.ROW_LEN(8), .SAMPLE_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_buffer (data_buffer),
    .out_pos     (out_pos),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  interp_window_feeder #(.ROW_LEN(5), .SAMPLE_W(8)) dut5 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data2),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .data_buffer (data_buffer2),
    .out_pos     (out_pos2),
    .out_last    (out_last2),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (ROW_LEN=8 instance) ----------------
  typedef struct {
    logic [63:0] data;
    int          pos;
    logic        last;
  } win_t;

  win_t        exp_q[$];
  win_t        cur;
  logic [7:0]  row_buf [0:N-1];
  int          row_idx = 0;
  logic [63:0] got_data [0:N-1];
  logic        got_last [0:N-1];

  // Window centred on x from the current row, padded per the build option.
  function automatic logic [63:0] model_win(input int x);
    logic [63:0] w;
    logic [7:0]  v;
    int          idx;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      idx = x - 3 + k;
      if (idx < 0) v = ZeroPad ? 8'd0 : row_buf[0];
      else if (idx > N - 1) v = ZeroPad ? 8'd0 : row_buf[N-1];
      else v = row_buf[idx];
      w[8*(7-k) +: 8] = v;
    end
    return w;
  endfunction

  task automatic push_win(input int x);
    win_t w;
    w.data = model_win(x);
    w.pos  = x;
    w.last = (x == N - 1);
    exp_q.push_back(w);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      row_idx = 0;
    end else begin
      // A window is on the output exactly while the model has one pending;
      // input is refused while stalled or while trailing windows remain.
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready),
          64'(((exp_q.size() == 0) || out_ready) && (exp_q.size() <= 1)));
      if (out_valid && exp_q.size() != 0) begin
        cur = exp_q[0];
        chk("win_data", 64'(data_buffer), cur.data);
        chk("win_pos", 64'(out_pos), 64'(cur.pos));
        chk("win_last", 64'(out_last), 64'(cur.last));
        if (out_ready) begin
          got_data[cur.pos] = data_buffer;
          got_last[cur.pos] = out_last;
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        row_buf[row_idx] = in_data;
        if (row_idx >= 4) push_win(row_idx - 4);
        if (row_idx == N - 1) begin
          for (int x = N - 4; x < N; x++) push_win(x);
          row_idx = 0;
        end else begin
          row_idx++;
        end
      end
    end
  end

  // ---------------- ROW_LEN=5 collector ----------------
  int          n2 = 0;
  logic [63:0] d2   [0:7];
  logic [2:0]  pos2 [0:7];
  logic        last2[0:7];

  always @(negedge clock) begin
    if (reset_n && out_valid2 && out_ready2) begin
      if (n2 < 8) begin
        d2[n2]    = data_buffer2;
        pos2[n2]  = out_pos2;
        last2[n2] = out_last2;
      end
      n2++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] stim [0:63];

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // vld_mode: 0 continuous, 1 random gaps.
  task automatic run(input int n, input int rdy_mode, input int vld_mode);
    int sent = 0;
    int cyc  = 0;
    int tog  = 0;
    logic acc;
    while ((sent < n || exp_q.size() != 0) && cyc < Budget) begin
      in_valid = (sent < n) && (vld_mode == 0 || $urandom_range(3) != 0);
      in_data  = (sent < n) ? stim[sent] : 8'h00;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (tog % 4 == 0) || (tog % 4 == 3);
        default: out_ready = ($urandom_range(2) != 0);
      endcase
      tog++;
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (cyc >= Budget) begin
      failures++;
      $display("FAIL run_timeout: sent %0d of %0d, pending %0d", sent, n, exp_q.size());
    end
  endtask

  task automatic run_short();
    int sent = 0;
    int cyc  = 0;
    logic acc;
    out_ready2 = 1'b1;
    while ((sent < 5 || n2 < 5) && cyc < 100) begin
      in_valid2 = (sent < 5);
      in_data2  = 8'(sent + 1);
      @(negedge clock);
      acc = in_valid2 && in_ready2;
      @(posedge clock);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid2 = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("short_count", 64'(n2), 64'd5);
    chk("short_x0", d2[0], ExpS0);
    chk("short_x4", d2[4], ExpS4);
    chk("short_pos", 64'({pos2[0], pos2[1], pos2[2], pos2[3], pos2[4]}),
        64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    chk("short_last", 64'({last2[0], last2[1], last2[2], last2[3], last2[4]}), 64'(5'b00001));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_data", 64'(data_buffer), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pos", 64'(out_pos), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // ROW_LEN=5 single row
    run_short();

    // Row 10..80, always ready
    for (int i = 0; i < N; i++) stim[i] = 8'(10 * (i + 1));
    run(N, 0, 0);
    chk("row_x0", got_data[0], ExpA0);
    chk("row_x7", got_data[7], ExpA7);
    chk("row_x7_last", 64'(got_last[7]), 64'd1);
    chk("model_pin_x0", model_win(0), ExpA0);

    // Same row with out_ready toggling 1,0,0,1
    run(N, 1, 0);
    chk("stall_x0", got_data[0], ExpA0);
    chk("stall_x7", got_data[7], ExpA7);

    // Two rows back to back, row 2 = 9..16
    for (int i = 0; i < 2 * N; i++) stim[i] = 8'(i + 1);
    run(2 * N, 0, 0);
    chk("row2_x0", got_data[0], ExpB0);

    // Async reset after three samples of a row
    stim[0] = 8'd7; stim[1] = 8'd8; stim[2] = 8'd9;
    run(3, 0, 0);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_data", 64'(data_buffer), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pos", 64'(out_pos), 64'd0);
    chk("arst_last", 64'(out_last), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) stim[i] = 8'(101 + i);
    run(N, 0, 0);
    chk("post_rst_x0", got_data[0], ExpR0);

    // Random rows with random valid/ready
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) stim[i] = 8'($urandom);
      run(40, 2, 1);
    end

    repeat (3) @(posedge clock);
    #1;
    chk("idle_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
